// File: rtl/muldiv_seq_unit.sv
// rtl/muldiv_seq_unit.sv - iterative RV32M multiply/divide unit with valid/ready request and response
module muldiv_seq_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [XLEN-1:0]  req_rs1,
  input  logic [XLEN-1:0]  req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy
);

  localparam int CW = $clog2(XLEN);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]     counter;
  logic [2:0]        op_q;
  logic [TAG_W-1:0]  tag_q;
  // Multiplicand for multiply, divisor magnitude for divide.
  logic [XLEN-1:0]   opnd_q;
  // Multiply: {partial high, remaining multiplier bits}. Divide: {remainder, quotient}.
  logic [2*XLEN-1:0] acc;
  logic              neg_q;
  logic              sign_a_q;
  logic              b_zero_q;

  logic              accept;
  logic              is_div;
  logic              sign_a;
  logic              sign_b;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] acc_step;
  logic [2*XLEN-1:0] prod_fixed;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fix_result;

  assign req_ready  = (state == IDLE) & ~flush;
  assign accept     = req_valid & req_ready;
  assign busy       = (state != IDLE);
  assign resp_valid = (state == DONE);

  // Operand sign extraction and magnitudes for the incoming request
  always_comb begin
    is_div = req_op[2];
    sign_a = 1'b0;
    sign_b = 1'b0;
    case (req_op)
      OP_MULH, OP_DIV, OP_REM: begin
        sign_a = req_rs1[XLEN-1];
        sign_b = req_rs2[XLEN-1];
      end
      OP_MULHSU: sign_a = req_rs1[XLEN-1];
      default: ;
    endcase
    mag_a = sign_a ? (~req_rs1 + 1'b1) : req_rs1;
    mag_b = sign_b ? (~req_rs2 + 1'b1) : req_rs2;
  end

  // One shift-add or restoring-divide iteration on the shared accumulator
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    div_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
    if (op_q[2]) begin
      if (!div_diff[XLEN]) acc_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else                 acc_step = {acc[2*XLEN-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc[XLEN-1:1]};
    end
  end

  // Sign fix-up and divide-by-zero override; signed overflow needs no special case
  // because magnitude division of 2^(XLEN-1) by 1 already yields the wrapped result.
  // A zero divisor leaves the remainder equal to |rs1|, so REM/REMU return rs1 naturally.
  always_comb begin
    prod_fixed = neg_q ? (~acc + 1'b1) : acc;
    quot       = acc[XLEN-1:0];
    rem        = acc[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                      fix_result = prod_fixed[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fixed[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU: begin
        if (b_zero_q)   fix_result = {XLEN{1'b1}};
        else if (neg_q) fix_result = ~quot + 1'b1;
        else            fix_result = quot;
      end
      OP_REM, OP_REMU: fix_result = sign_a_q ? (~rem + 1'b1) : rem;
      default:         fix_result = quot;
    endcase
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = CALC;
      CALC: if (counter == CW'(XLEN-1)) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Operand capture, iteration datapath and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      counter   <= '0;
      op_q      <= '0;
      tag_q     <= '0;
      opnd_q    <= '0;
      acc       <= '0;
      neg_q     <= 1'b0;
      sign_a_q  <= 1'b0;
      b_zero_q  <= 1'b0;
      resp_data <= '0;
      resp_tag  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            counter  <= '0;
            op_q     <= req_op;
            tag_q    <= req_tag;
            neg_q    <= sign_a ^ sign_b;
            sign_a_q <= sign_a;
            b_zero_q <= (req_rs2 == '0);
            opnd_q   <= is_div ? mag_b : mag_a;
            acc      <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
          end
        end
        CALC: begin
          if (!flush) begin
            acc     <= acc_step;
            counter <= counter + 1'b1;
          end
        end
        FIX: begin
          if (!flush) begin
            resp_data <= fix_result;
            resp_tag  <= tag_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// tb/tb_muldiv_seq_unit.sv - scoreboard bench for muldiv_seq_unit
module tb_muldiv_seq_unit;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [XLEN-1:0]  req_rs1;
  logic [XLEN-1:0]  req_rs2;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic [XLEN-1:0]  resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             busy;

  muldiv_seq_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_tag(resp_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0]  data;
    logic [TAG_W-1:0] tag;
    int               acc_cyc;
    string            name;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: latency on rising resp_valid, data/tag on each handshake
  always @(negedge clk) begin
    if (!rst && resp_valid && !prev_valid) begin
      if (exp_q.size() == 0) check("unexpected_resp_valid", 64'd1, 64'd0);
      else check({exp_q[0].name, "_latency"}, 64'(cyc - exp_q[0].acc_cyc), 64'd33);
    end
    if (!rst && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_handshake", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_data"}, 64'(resp_data), 64'(e.data));
        check({e.name, "_tag"}, 64'(resp_tag), 64'(e.tag));
      end
    end
    prev_valid <= resp_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input string name, input logic [2:0] op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag,
                       input logic [XLEN-1:0] exp_data, input bit expect_resp);
    exp_t e;
    int   n = 0;
    while (!req_ready && n < 100) begin tick(); n++; end
    if (!req_ready) check({name, "_req_ready_timeout"}, 64'd0, 64'd1);
    req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_tag = tag;
    if (expect_resp) begin
      e.data = exp_data; e.tag = tag; e.acc_cyc = cyc + 1; e.name = name;
      exp_q.push_back(e);
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!resp_valid && n < 100) begin tick(); n++; end
    if (!resp_valid) check({name, "_resp_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag,
                        input logic [XLEN-1:0] exp_data);
    issue(name, op, a, b, tag, exp_data, 1'b1);
    wait_valid(name);
    tick();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = '0;
    req_rs1 = '0; req_rs2 = '0; req_tag = '0; resp_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    check("reset_resp_valid", 64'(resp_valid), 64'd0);
    check("reset_resp_data", 64'(resp_data), 64'd0);
    check("reset_resp_tag", 64'(resp_tag), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_req_ready", 64'(req_ready), 64'd1);

    run_op("mul_7_m3",      3'b000, 32'd7,         32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB);
    run_op("mulh_min_min",  3'b001, 32'h80000000, 32'h80000000, 5'd1,  32'h40000000);
    run_op("mulhu_max_max", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE);
    run_op("mulhsu_m1_2",   3'b010, 32'hFFFFFFFF, 32'd2,        5'd3,  32'hFFFFFFFF);
    run_op("div_m7_2",      3'b100, 32'hFFFFFFF9, 32'd2,        5'd4,  32'hFFFFFFFD);
    run_op("rem_m7_2",      3'b110, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF);
    run_op("divu_100_7",    3'b101, 32'd100,      32'd7,        5'd7,  32'd14);
    run_op("remu_100_7",    3'b111, 32'd100,      32'd7,        5'd8,  32'd2);
    run_op("div_by_zero",   3'b100, 32'hFFFFFFFB, 32'd0,        5'd10, 32'hFFFFFFFF);
    run_op("rem_by_zero",   3'b110, 32'hFFFFFFFB, 32'd0,        5'd11, 32'hFFFFFFFB);
    run_op("divu_by_zero",  3'b101, 32'd9,        32'd0,        5'd12, 32'hFFFFFFFF);
    run_op("div_overflow",  3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000);
    run_op("rem_overflow",  3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'd0);

    // Back-pressure: response must hold while resp_ready is low
    resp_ready = 1'b0;
    issue("hold_divu", 3'b101, 32'd100, 32'd7, 5'd9, 32'd14, 1'b1);
    wait_valid("hold_divu");
    for (int i = 0; i < 5; i++) begin
      check("hold_resp_valid", 64'(resp_valid), 64'd1);
      check("hold_resp_data", 64'(resp_data), 64'd14);
      check("hold_resp_tag", 64'(resp_tag), 64'd9);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    check("post_hs_busy", 64'(busy), 64'd0);
    check("post_hs_req_ready", 64'(req_ready), 64'd1);
    check("post_hs_resp_valid", 64'(resp_valid), 64'd0);

    // Flush in the middle of CALC
    issue("flush_mul", 3'b000, 32'd3, 32'd5, 5'd15, 32'd0, 1'b0);
    repeat (9) tick();
    check("flush_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    check("flush_blocks_ready", 64'(req_ready), 64'd0);
    tick();
    flush = 1'b0;
    check("flush_busy_after", 64'(busy), 64'd0);
    begin
      int seen = 0;
      for (int i = 0; i < 40; i++) begin
        if (resp_valid) seen++;
        tick();
      end
      check("flush_no_resp", 64'(seen), 64'd0);
    end

    // Reset in the middle of CALC
    issue("rst_mul", 3'b000, 32'd3, 32'd5, 5'd16, 32'd0, 1'b0);
    repeat (12) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_mid_resp_data", 64'(resp_data), 64'd0);
    check("rst_mid_resp_tag", 64'(resp_tag), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);

    run_op("mulhu_3_5", 3'b011, 32'd3, 32'd5, 5'd17, 32'd0);
    run_op("mul_3_5",   3'b000, 32'd3, 32'd5, 5'd18, 32'd15);

    repeat (3) tick();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
